key_led_ctrl: RTL

Controller that sequences the board LED register from a single push-button. It synchronises and debounces the raw key, then detects press events. On each press it steps a four-mode FSM: OFF, ON, SLOW blink, FAST blink. It drives the registered led_out accordingly and sits between the key pin and the LED pin at top level.

---
 rtl/key_led_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/key_led_ctrl.sv
// Push-button LED controller: synchronise, debounce, detect presses, step OFF/ON/SLOW/FAST.
// Optional macro LONG_PRESS_EN: holding the key for LONG_PRESS_CNT debounced clocks forces OFF.
module key_led_ctrl #(
   parameter int DEBOUNCE_CNT   = 1_000_000,
   parameter int SLOW_HALF      = 25_000_000,
   parameter int FAST_HALF      = 6_250_000,
   parameter int LONG_PRESS_CNT = 100_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic       led_out,
   output logic [1:0] mode,
   output logic       key_flag
);

   localparam int  DW     = $clog2(DEBOUNCE_CNT + 1);
   localparam int  HMAX   = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
   localparam int  BW     = $clog2(HMAX + 1);
   localparam bit  CFG_OK = (DEBOUNCE_CNT >= 2) && (SLOW_HALF >= 2) && (FAST_HALF >= 2) &&
                            (LONG_PRESS_CNT > DEBOUNCE_CNT);

   if (!CFG_OK) begin : g_cfg_check
      $error("key_led_ctrl: invalid parameter set");
   end

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_ON   = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_FAST = 2'd3
   } mode_e;

   logic          sync1_q, sync1_d, sync2_q, sync2_d;
   logic          deb_q, deb_d;
   logic [DW-1:0] deb_cnt_q, deb_cnt_d;
   logic          flag_q, flag_d;
   mode_e         mode_q, mode_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          phase_q, phase_d;
   logic          led_q, led_d;
   logic [BW-1:0] half_max;

`ifdef LONG_PRESS_EN
   localparam int LW = $clog2(LONG_PRESS_CNT + 1);
   logic [LW-1:0] hold_cnt_q, hold_cnt_d;
   logic          long_done_q, long_done_d;
`endif

   // Synchroniser and debounce: a new level must persist DEBOUNCE_CNT clocks.
   always_comb begin
      sync1_d   = key_in;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_cnt_d = '0;
      flag_d    = 1'b0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DW'(DEBOUNCE_CNT - 1)) begin
            deb_d  = sync2_q;
            flag_d = ~sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (flag_q) begin
         mode_d = mode_e'(mode_q + 2'd1);
      end
`ifdef LONG_PRESS_EN
      hold_cnt_d  = '0;
      long_done_d = 1'b0;
      if (!deb_q) begin
         hold_cnt_d  = (hold_cnt_q == LW'(LONG_PRESS_CNT - 1)) ? hold_cnt_q : hold_cnt_q + 1'b1;
         long_done_d = long_done_q;
         if (hold_cnt_q == LW'(LONG_PRESS_CNT - 1) && !long_done_q) begin
            mode_d      = MODE_OFF;
            long_done_d = 1'b1;
         end
      end
`endif
   end

   // Blink engine; a mode change restarts the half-period lit, overriding any wrap.
   always_comb begin
      half_max    = (mode_q == MODE_FAST) ? BW'(FAST_HALF - 1) : BW'(SLOW_HALF - 1);
      blink_cnt_d = '0;
      phase_d     = phase_q;
      if (mode_d != mode_q) begin
         phase_d = 1'b1;
      end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
         if (blink_cnt_q == half_max) begin
            phase_d = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      case (mode_q)
         MODE_OFF: led_d = 1'b0;
         MODE_ON:  led_d = 1'b1;
         default:  led_d = phase_q;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         deb_q       <= 1'b1;
         deb_cnt_q   <= '0;
         flag_q      <= 1'b0;
         mode_q      <= MODE_OFF;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         led_q       <= 1'b0;
`ifdef LONG_PRESS_EN
         hold_cnt_q  <= '0;
         long_done_q <= 1'b0;
`endif
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         deb_cnt_q   <= deb_cnt_d;
         flag_q      <= flag_d;
         mode_q      <= mode_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         led_q       <= led_d;
`ifdef LONG_PRESS_EN
         hold_cnt_q  <= hold_cnt_d;
         long_done_q <= long_done_d;
`endif
      end
   end

   assign led_out  = led_q;
   assign mode     = mode_q;
   assign key_flag = flag_q;

endmodule
